// File: rtl/logic_op_pkg.sv
// Shared opcode and FSM encodings for the logic-op arbiter slice.
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_NOT  = 2'b00,
    OP_NOR  = 2'b01,
    OP_OR   = 2'b10,
    OP_IMPL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EVAL = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise logic unit: NOT, NOR, OR, IMPLICATION over WIDTH bits.
module logic_op_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] or_ab;
  logic [WIDTH-1:0] not_a;

  assign or_ab = a | b;
  assign not_a = ~a;

  always_comb begin
    y = '0;
    case (op)
      OP_NOT:  y = not_a;
      OP_NOR:  y = ~or_ab;
      OP_OR:   y = or_ab;
      OP_IMPL: y = not_a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered logic unit between NREQ requesters.
// Optional completed-operation counter enabled by LOGIC_ARB_OPCOUNT_EN.
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_data,
  output logic [15:0]           op_count
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   g_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] unit_y;

  logic             gnt_found;
  logic             grant_ok;
  int unsigned      gnt_idx;
  int unsigned      scan_idx;

  // Scan upward from the pointer, wrapping, and take the first valid requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = (32'(ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign grant_ok  = gnt_found && (state_q == ST_IDLE) && !rst;
  assign req_ready = grant_ok ? (NREQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_ok) state_d = ST_EVAL;
      ST_EVAL: state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      g_q        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_ok) begin
            op_q <= req_op[2*gnt_idx +: 2];
            a_q  <= req_a[WIDTH*gnt_idx +: WIDTH];
            b_q  <= req_b[WIDTH*gnt_idx +: WIDTH];
            g_q  <= IDW'(gnt_idx);
          end
        end
        ST_EVAL: begin
          resp_data  <= unit_y;
          resp_id    <= g_q;
          resp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            ptr_q      <= (g_q == IDW'(NREQ - 1)) ? '0 : g_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic_op_unit #(.WIDTH(WIDTH)) u_unit (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (unit_y)
  );

`ifdef LOGIC_ARB_OPCOUNT_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk) begin
    if (rst)
      op_count_q <= '0;
    else if (resp_valid && resp_ready && (op_count_q != '1))
      op_count_q <= op_count_q + 16'd1;
  end

  assign op_count = op_count_q;
`else
  assign op_count = '0;
`endif

endmodule
